// File: rtl/alk_pkg.sv
// Shared types for the ALUSHF shift sequencer: op codes, FSM states, fill sources.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alk_pkg;

    // ALUSHF micro-op codes, encoded exactly as they appear on alushf_h
    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_SL1 = 3'b001,
        OP_SL0 = 3'b010,
        OP_ROT = 3'b011,
        OP_SR0 = 3'b100,
        OP_SR1 = 3'b101,
        OP_ASR = 3'b110,
        OP_RSV = 3'b111
    } alushf_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Bit shifted into the vacated end of A:Q on each step
    typedef enum logic [1:0] {
        FILL_ZERO = 2'd0,
        FILL_ONE  = 2'd1,
        FILL_AMSB = 2'd2
    } fill_e;

endpackage

// File: rtl/alk_shfseq_if.sv
// Command/result bundle of the shift sequencer; master drives commands, slave is the sequencer.
// Latency: none (wires only).
// Backpressure: none; start_h is simply dropped while busy_h is high.
// Ports: start_h/alushf_h/count_h/a_in_h/q_in_h/abort_h toward the sequencer,
//        a_out_h/q_out_h/busy_h/done_h/err_h back to the master.
interface alk_shfseq_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             start_h;
    logic [2:0]       alushf_h;
    logic [CNT_W-1:0] count_h;
    logic [WIDTH-1:0] a_in_h;
    logic [WIDTH-1:0] q_in_h;
    logic             abort_h;
    logic [WIDTH-1:0] a_out_h;
    logic [WIDTH-1:0] q_out_h;
    logic             busy_h;
    logic             done_h;
    logic             err_h;

    modport master (
        output start_h, alushf_h, count_h, a_in_h, q_in_h, abort_h,
        input  a_out_h, q_out_h, busy_h, done_h, err_h
    );

    modport slave (
        input  start_h, alushf_h, count_h, a_in_h, q_in_h, abort_h,
        output a_out_h, q_out_h, busy_h, done_h, err_h
    );
endinterface

// File: rtl/alk_shfdec.sv
// Combinational ALUSHF decoder: direction, fill source, rotate enable, reserved flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
// Ports: op in; dir_right, fill_sel, rot_en, rsv out.
// Build option: ALK_SHFSEQ_ROT_EN makes 011 a left rotate; without it 011 decodes as reserved.
module alk_shfdec
    import alk_pkg::*;
(
    input  alushf_e op,
    output logic    dir_right,
    output fill_e   fill_sel,
    output logic    rot_en,
    output logic    rsv
);

    always_comb begin
        dir_right = 1'b0;
        fill_sel  = FILL_ZERO;
        rot_en    = 1'b0;
        rsv       = 1'b0;
        case (op)
            OP_NOP: ;
            OP_SL1: fill_sel = FILL_ONE;
            OP_SL0: fill_sel = FILL_ZERO;
`ifdef ALK_SHFSEQ_ROT_EN
            OP_ROT: rot_en = 1'b1;
`else
            OP_ROT: rsv = 1'b1;
`endif
            OP_SR0: dir_right = 1'b1;
            OP_SR1: begin
                dir_right = 1'b1;
                fill_sel  = FILL_ONE;
            end
            OP_ASR: begin
                dir_right = 1'b1;
                fill_sel  = FILL_AMSB;
            end
            default: rsv = 1'b1;
        endcase
    end

endmodule

// File: rtl/alk_shfseq.sv
// Multi-cycle A:Q shift sequencer: one bit step per SHIFT cycle, IDLE/SHIFT/DONE control.
// Latency: done_h count+1 cycles after the start edge; 1 cycle for NOP, reserved code or count 0.
// Backpressure: start_h ignored (not queued) unless the state is IDLE; abort_h cancels SHIFT.
// Ports: clk_h, reset_h (async active-high); bus = alk_shfseq_if.slave.
// Build option: ALK_SHFSEQ_ROT_EN enables op 011 as a left rotate of A:Q.
module alk_shfseq
    import alk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk_h,
    input  logic         reset_h,
    alk_shfseq_if.slave  bus
);

    localparam int AQ_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state_q, state_d;
    logic [AQ_W-1:0]   aq_q, aq_step;
    logic [CNT_W-1:0]  cnt_q;
    alushf_e           op_q, dec_op;
    logic              dir_right, rot_en, rsv, fill_bit;
    fill_e             fill_sel;
    logic              load, step;

    // One decoder serves both phases: in IDLE it classifies the incoming
    // command, afterwards it decodes the captured op (also sourcing err_h in DONE).
    assign dec_op = (state_q == ST_IDLE) ? alushf_e'(bus.alushf_h) : op_q;

    alk_shfdec u_dec (
        .op        (dec_op),
        .dir_right (dir_right),
        .fill_sel  (fill_sel),
        .rot_en    (rot_en),
        .rsv       (rsv)
    );

    // A rotate feeds A[msb] into Q[0], the same bit ASR replicates into A[msb]
    always_comb begin
        fill_bit = 1'b0;
        if (rot_en) begin
            fill_bit = aq_q[AQ_W-1];
        end else begin
            case (fill_sel)
                FILL_ONE:  fill_bit = 1'b1;
                FILL_AMSB: fill_bit = aq_q[AQ_W-1];
                default:   fill_bit = 1'b0;
            endcase
        end
        aq_step = dir_right ? {fill_bit, aq_q[AQ_W-1:1]}
                            : {aq_q[AQ_W-2:0], fill_bit};
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_h) begin
                    load = 1'b1;
                    if (bus.count_h == '0 || dec_op == OP_NOP || rsv) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                // The abort cycle still steps, so A:Q holds the partial result;
                // abort wins over the terminal step and suppresses DONE.
                step = 1'b1;
                if (bus.abort_h) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state_q <= ST_IDLE;
            aq_q    <= '0;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            if (load) begin
                aq_q  <= {bus.a_in_h, bus.q_in_h};
                cnt_q <= bus.count_h;
                op_q  <= alushf_e'(bus.alushf_h);
            end else if (step) begin
                aq_q  <= aq_step;
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    assign bus.a_out_h = aq_q[AQ_W-1:WIDTH];
    assign bus.q_out_h = aq_q[WIDTH-1:0];
    assign bus.busy_h  = (state_q != ST_IDLE);
    assign bus.done_h  = (state_q == ST_DONE);
    assign bus.err_h   = (state_q == ST_DONE) && rsv;

endmodule

// File: tb/tb_alk_shfseq.sv
// Directed scoreboard bench for alk_shfseq at WIDTH=8.
// Latency: expected done_h cycle is tracked per command.
// Backpressure: exercises start-while-busy, start on DONE exit and abort cases.
module tb_alk_shfseq;

`ifdef ALK_SHFSEQ_ROT_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic clk;
    logic rst;

    alk_shfseq_if #(.WIDTH(8), .CNT_W(6)) bus ();

    alk_shfseq #(.WIDTH(8), .CNT_W(6)) dut (
        .clk_h   (clk),
        .reset_h (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] q;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one command on the 16-bit A:Q value
    function automatic logic [15:0] mdl(input logic [2:0] op, input int cnt, input logic [15:0] aq0);
        logic [15:0] aq;
        aq = aq0;
        for (int i = 0; i < cnt; i++) begin
            case (op)
                3'd1: aq = {aq[14:0], 1'b1};
                3'd2: aq = {aq[14:0], 1'b0};
                3'd3: if (ROT) aq = {aq[14:0], aq[15]};
                3'd4: aq = {1'b0, aq[15:1]};
                3'd5: aq = {1'b1, aq[15:1]};
                3'd6: aq = {aq[15], aq[15:1]};
                default: ;
            endcase
        end
        return aq;
    endfunction

    // Drive a command (call at a negedge); optionally push its expectation
    task automatic send(input logic [2:0] op, input int cnt, input logic [7:0] a,
                        input logic [7:0] q, input bit push);
        exp_t        e;
        logic [15:0] r;
        bit          rsv;
        rsv = (op == 3'd7) || (op == 3'd3 && !ROT);
        if (rsv || op == 3'd0 || cnt == 0) begin
            r     = {a, q};
            e.lat = 1;
        end else begin
            r     = mdl(op, cnt, {a, q});
            e.lat = cnt + 1;
        end
        e.a   = r[15:8];
        e.q   = r[7:0];
        e.err = rsv;
        if (push) sb.push_back(e);
        bus.alushf_h = op;
        bus.count_h  = 6'(cnt);
        bus.a_in_h   = a;
        bus.q_in_h   = q;
        bus.start_h  = 1'b1;
    endtask

    // Called just after the start edge; returns at the negedge inside DONE
    task automatic wait_done(input string tag);
        exp_t e;
        int   n;
        bit   seen;
        n    = 1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done_h === 1'b1) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk({tag, "_a"}, 32'(bus.a_out_h), 32'(e.a));
        chk({tag, "_q"}, 32'(bus.q_out_h), 32'(e.q));
        chk({tag, "_err"}, 32'(bus.err_h), 32'(e.err));
        chk({tag, "_lat"}, 32'(n), 32'(e.lat));
        chk({tag, "_busy_in_done"}, 32'(bus.busy_h), 32'd1);
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] op, input int cnt,
                           input logic [7:0] a, input logic [7:0] q);
        send(op, cnt, a, q, 1'b1);
        @(posedge clk);
        #1 bus.start_h = 1'b0;
        wait_done(tag);
        @(negedge clk);
        chk({tag, "_idle_after"}, {30'd0, bus.busy_h, bus.done_h}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start_h  = 1'b0;
        bus.alushf_h = 3'd0;
        bus.count_h  = '0;
        bus.a_in_h   = '0;
        bus.q_in_h   = '0;
        bus.abort_h  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a", 32'(bus.a_out_h), 32'd0);
        chk("rst_q", 32'(bus.q_out_h), 32'd0);
        chk("rst_busy", 32'(bus.busy_h), 32'd0);
        chk("rst_done", 32'(bus.done_h), 32'd0);
        chk("rst_err", 32'(bus.err_h), 32'd0);

        // First command accepted on the very first edge after reset release
        rst = 1'b0;
        run_cmd("sl0_c3", 3'd2, 3, 8'h81, 8'h40);
        run_cmd("sr1_c2", 3'd5, 2, 8'h00, 8'h03);
        run_cmd("rot_c16", 3'd3, 16, 8'h5A, 8'hC3);
        run_cmd("sl1_c5", 3'd1, 5, 8'h00, 8'h00);
        run_cmd("sr0_c4", 3'd4, 4, 8'hF0, 8'h0F);
        run_cmd("asr_c3", 3'd6, 3, 8'h80, 8'h01);
        run_cmd("rot_c20", 3'd3, 20, 8'h81, 8'h00);
        run_cmd("sl1_c63", 3'd1, 63, 8'h00, 8'h00);
        run_cmd("nop_c5", 3'd0, 5, 8'h12, 8'h34);
        run_cmd("rsv_c9", 3'd7, 9, 8'hAB, 8'hCD);
        run_cmd("sl0_c0", 3'd2, 0, 8'h77, 8'h88);

        // abort_h in IDLE and DONE has no effect
        bus.abort_h = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle_busy", 32'(bus.busy_h), 32'd0);
        chk("abort_idle_a", 32'(bus.a_out_h), 32'h77);
        run_cmd("abort_done_c0", 3'd1, 0, 8'h3C, 8'h5A);
        bus.abort_h = 1'b0;

        // start_h held high through SHIFT and on the DONE->IDLE edge is ignored
        send(3'd2, 4, 8'h01, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        bus.alushf_h = 3'd5;
        bus.count_h  = 6'd1;
        bus.a_in_h   = 8'hFF;
        bus.q_in_h   = 8'hFF;
        wait_done("busy_ign");
        @(posedge clk);
        #1 bus.start_h = 1'b0;
        @(negedge clk);
        chk("busy_ign_idle", 32'(bus.busy_h), 32'd0);
        chk("busy_ign_a", 32'(bus.a_out_h), 32'h10);
        chk("busy_ign_q", 32'(bus.q_out_h), 32'h00);

        // Abort in the 2nd SHIFT cycle keeps the partial result, no done_h
        send(3'd6, 3, 8'h80, 8'h00, 1'b0);
        @(posedge clk);
        #1 bus.start_h = 1'b0;
        @(posedge clk);
        #1 bus.abort_h = 1'b1;
        @(posedge clk);
        #1 bus.abort_h = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy_h), 32'd0);
        chk("abort_done", 32'(bus.done_h), 32'd0);
        chk("abort_a", 32'(bus.a_out_h), 32'hE0);
        chk("abort_q", 32'(bus.q_out_h), 32'h00);
        @(negedge clk);
        chk("abort_no_late_done", 32'(bus.done_h), 32'd0);

        // Abort wins over the terminal step
        send(3'd2, 2, 8'h01, 8'h00, 1'b0);
        @(posedge clk);
        #1 bus.start_h = 1'b0;
        @(posedge clk);
        #1 bus.abort_h = 1'b1;
        @(posedge clk);
        #1 bus.abort_h = 1'b0;
        @(negedge clk);
        chk("abort_term_done", 32'(bus.done_h), 32'd0);
        chk("abort_term_busy", 32'(bus.busy_h), 32'd0);
        chk("abort_term_a", 32'(bus.a_out_h), 32'h04);

        // Reset mid-SHIFT acts without a clock edge
        send(3'd1, 10, 8'h12, 8'h34, 1'b0);
        @(posedge clk);
        #1 bus.start_h = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_a", 32'(bus.a_out_h), 32'd0);
        chk("midrst_q", 32'(bus.q_out_h), 32'd0);
        chk("midrst_busy", 32'(bus.busy_h), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_cmd("post_rst_sl0", 3'd2, 1, 8'h40, 8'h80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alk_shfseq.md
ALK_SHFSEQ -- requirements
Module: alk_shfseq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the width of each of the A and Q halves.
REQ-002 The block SHALL have parameter CNT_W, default 6, meaning the width of the shift count.
REQ-003 clk_h  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset_h  in  1  asynchronous, active-high reset.
REQ-005 start_h  in  1  command strobe, sampled only in IDLE.
REQ-006 alushf_h  in  3  ALUSHF micro-op code, captured with start_h.
REQ-007 count_h  in  CNT_W  number of one-bit steps, captured with start_h.
REQ-008 a_in_h, q_in_h  in  WIDTH each  operand halves, captured with start_h.
REQ-009 abort_h  in  1  synchronous cancel of a sequence in progress.
REQ-010 a_out_h, q_out_h  out  WIDTH each  working A:Q register contents.
REQ-011 busy_h  out  1  high in SHIFT and DONE.
REQ-012 done_h  out  1  one-cycle completion pulse.
REQ-013 err_h  out  1  one-cycle pulse on a reserved code.

Function
REQ-014 A:Q SHALL be a 2*WIDTH register, with A as the most significant half, advanced one bit position per SHIFT cycle.
REQ-015 The op codes SHALL be:
- 000 NOP: no movement.
- 001 left shift, 1 into Q[0].
- 010 left shift, 0 into Q[0].
- 011 left rotate, A[WIDTH-1] into Q[0].
- 100 right shift, 0 into A[msb].
- 101 right shift, 1 into A[msb].
- 110 arithmetic right shift, A[msb] preserved.
- 111 reserved.
REQ-016 The state machine SHALL have the states IDLE, SHIFT and DONE.
REQ-017 IDLE with start_h=1 SHALL load A, Q, op and count, then go to SHIFT, or to DONE if count_h=0, op=NOP or the code is reserved.
REQ-018 In SHIFT, each cycle SHALL perform one step and decrement the counter; the step that takes the counter from 1 to 0 SHALL move the block to DONE.
REQ-019 DONE SHALL assert done_h for exactly one cycle, then return to IDLE.
REQ-020 Latency from the start_h edge to the done_h cycle SHALL be count+1 cycles; for NOP, reserved codes or count 0 it SHALL be 1 cycle.
REQ-021 start_h SHALL be ignored while busy_h=1, with no queuing.
REQ-022 A start_h asserted in the same cycle that DONE returns to IDLE SHALL be ignored; a new command is accepted only in a cycle where the state is IDLE.
REQ-023 abort_h in SHIFT SHALL move the block to IDLE on the next edge, with no done_h, and A:Q SHALL retain the partial result.
REQ-024 abort_h in IDLE or DONE SHALL have no effect.
REQ-025 abort_h SHALL take priority over a terminal step in the same cycle.
REQ-026 A reserved code SHALL pulse err_h in the DONE cycle, together with done_h, and leave A:Q equal to the loaded values.
REQ-027 The count SHALL NOT saturate or wrap: counts up to 2^CNT_W-1 are legal, and a count of 2*WIDTH or more SHALL keep stepping, so a rotate returns to an earlier value.
REQ-028 a_out_h and q_out_h SHALL be registered outputs reflecting A:Q after each step.

Reset
REQ-029 reset_h=1 SHALL immediately force state IDLE, A=0, Q=0, counter=0, op=000 and busy_h=done_h=err_h=0.
REQ-030 A reset in the middle of a sequence SHALL discard the sequence.
REQ-031 After reset_h deasserts, the first start_h SHALL be accepted on the first rising clock edge.

Configuration
REQ-032 The macro ALK_SHFSEQ_ROT_EN, when defined, SHALL compile in code 011 as a rotate.
REQ-033 When ALK_SHFSEQ_ROT_EN is undefined, code 011 SHALL be reserved: no movement, err_h pulse, and no rotate logic present.

Structure
REQ-034 A shared package alk_pkg SHALL hold the enumerated op codes (NOP, SL1, SL0, ROT, SR0, SR1, ASR, RSV) and the FSM state typedef.
REQ-035 A combinational sub-module alk_shfdec SHALL decode alushf_h into:
- shift direction;
- fill-bit source select;
- rotate enable;
- reserved flag.
REQ-036 The sequencer, counter and A:Q register SHALL reside in alk_shfseq.

Verification
REQ-037 With WIDTH=8, op 010, count 3, A=0x81, Q=0x40, done_h SHALL pulse at cycle 4 with A=0x0A and Q=0x00.
REQ-038 With op 101, count 2, A=0x00, Q=0x03, the result SHALL be A=0xC0 and Q=0x00.
REQ-039 With op 011, count 16, A=0x5A, Q=0xC3, the result SHALL be unchanged with ROT_EN defined; with it undefined, err_h and done_h SHALL pulse at cycle 1 with data unchanged.
REQ-040 With op 110, count 3, A=0x80, abort_h asserted in the 2nd SHIFT cycle, there SHALL be no done_h, A SHALL be 0xE0 and the next state SHALL be IDLE.
REQ-041 A start_h asserted while busy SHALL be ignored; count 0 SHALL give done_h at cycle 1 with no data change.
REQ-042 A reset_h assertion in the middle of SHIFT SHALL zero the outputs and deassert busy_h without waiting for a clock edge.
